data_memory_initiator: RTL and testbench
========================================

DATA_MEMORY_INITIATOR -- requirements
Module: data_memory_initiator

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, giving the maximum ACCESS cycles with data_memoryBusy high before abort (range 1..65535).
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port RSTB, input, 1, reset: synchronous, active-low.
REQ-004 SHALL have port req_valid, input, 1, core requests an access.
REQ-005 SHALL have port req_ready, output, 1, block can accept a request.
REQ-006 SHALL have port req_write, input, 1, 1=store, 0=load.
REQ-007 SHALL have port req_size, input, 2, 00 byte, 01 half, 10 word, 11 reserved.
REQ-008 SHALL have port req_signed, input, 1, sign-extend load result.
REQ-009 SHALL have port req_address, input, 32, byte address.
REQ-010 SHALL have port req_writeData, input, 32, store data, right-aligned.
REQ-011 SHALL have port rsp_valid, output, 1, one-cycle response strobe.
REQ-012 SHALL have port rsp_readData, output, 32, aligned and extended load result.
REQ-013 SHALL have port rsp_fault, output, 1, access fault or timeout.
REQ-014 SHALL have port rsp_timeout, output, 1, abort due to TIMEOUT_CYCLES.
REQ-015 SHALL have port rsp_misaligned, output, 1, misaligned or reserved-size request.
REQ-016 SHALL have ports data_memoryAddress (out, 32), data_memoryByteSelect (out, 4), data_memoryEnable (out, 1), data_memoryWriteEnable (out, 1), data_memoryDataWrite (out, 32), forming the memory-side request.
REQ-017 SHALL have ports data_memoryDataRead (in, 32), data_memoryBusy (in, 1), data_memoryAccessFault (in, 1), forming the memory-side response.

Function
REQ-018 SHALL implement states IDLE, ACCESS, RESPOND; req_ready = (state==IDLE).
REQ-019 IDLE: on req_valid, latch request; aligned -> ACCESS, misaligned/reserved -> RESPOND with misaligned flag set, no memory enable.
REQ-020 Misaligned: half with address[0]=1, word with address[1:0]!=00, any req_size=11.
REQ-021 data_memoryAddress SHALL be {req_address[31:2],2'b00}; byteSelect byte=0001<<a[1:0], half=0011<<a[1:0], word=1111.
REQ-022 data_memoryDataWrite SHALL be write data replicated/shifted onto selected lanes (byte at lane a[1:0], half at lanes a[1]*2), unselected lanes 0.
REQ-023 ACCESS: data_memoryEnable=1, WriteEnable=req_write, all memory outputs stable; stay while data_memoryBusy=1.
REQ-024 ACCESS with data_memoryBusy=0: capture data_memoryAccessFault, go RESPOND at that edge.
REQ-025 Busy cycle counter SHALL increment each ACCESS cycle with busy=1; reaching TIMEOUT_CYCLES -> RESPOND with rsp_fault=1, rsp_timeout=1, enable dropped.
REQ-026 RESPOND: rsp_valid=1 for exactly one cycle, data_memoryEnable=0, then IDLE.
REQ-027 rsp_readData for loads SHALL be data_memoryDataRead in RESPOND, shifted down by a[1:0]*8, zero- or sign-extended per req_signed/size; stores, faults, misaligned -> 0.
REQ-028 Minimum latency: accept cycle T, enable T+1, rsp_valid T+2, next accept T+3.
REQ-029 req_ready, rsp_* and data_memory* outputs SHALL be 0 whenever not in the state defining them.

Reset
REQ-030 RSTB low at a rising edge SHALL force IDLE, clear counter and latched request; all outputs 0 except req_ready=1 from next cycle.
REQ-031 Reset during ACCESS/RESPOND SHALL abort with no rsp_valid and enable low the cycle after the reset edge.

Verification
REQ-032 Word 0x100=0x8899AABB; LB signed @0x103 -> address 0x100, byteSelect 1000, rsp_readData 0xFFFFFF88 at T+2.
REQ-033 LHU @0x102 -> byteSelect 1100, rsp_readData 0x00008899; LW @0x100 -> 0x8899AABB.
REQ-034 SB @0x101 data 0x0000005A -> WriteEnable=1, byteSelect 0010, DataWrite 0x00005A00, rsp_valid with rsp_readData 0.
REQ-035 LW @0x102 -> no data_memoryEnable, rsp_valid+rsp_misaligned at T+1.
REQ-036 Busy high 3 ACCESS cycles -> outputs held, rsp_valid T+5; busy stuck with TIMEOUT_CYCLES=4 -> rsp_fault=rsp_timeout=1 after 4 ACCESS cycles.
REQ-037 RSTB low during ACCESS -> enable 0 next cycle, no rsp_valid, req_ready 1 after release.

Source files
------------

// File: rtl/data_memory_initiator.sv
// Load/store initiator between a core and a data memory with lane alignment,
// sign/zero extension, misalignment detection and a busy timeout.
module data_memory_initiator #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        RSTB,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_address,
  input  logic [31:0] req_writeData,
  output logic        rsp_valid,
  output logic [31:0] rsp_readData,
  output logic        rsp_fault,
  output logic        rsp_timeout,
  output logic        rsp_misaligned,
  output logic [31:0] data_memoryAddress,
  output logic [3:0]  data_memoryByteSelect,
  output logic        data_memoryEnable,
  output logic        data_memoryWriteEnable,
  output logic [31:0] data_memoryDataWrite,
  input  logic [31:0] data_memoryDataRead,
  input  logic        data_memoryBusy,
  input  logic        data_memoryAccessFault,
  output logic [1:0]  dbg_state
);

  // Handshake: a request transfers on a rising edge where req_valid and
  // req_ready are both high; rsp_valid is a single-cycle strobe, no back-pressure.

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    RESPOND = 2'd2
  } state_t;

  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      state;
  logic [15:0] busy_cnt;
  logic        lat_write;
  logic [1:0]  lat_size;
  logic        lat_signed;
  logic [1:0]  lat_offset;
  logic [29:0] lat_word_addr;
  logic [3:0]  lat_byte_sel;
  logic [31:0] lat_lanes;
  logic        lat_misaligned;
  logic        lat_fault;
  logic        lat_timeout;

  logic        in_misaligned;
  logic [3:0]  in_byte_sel;
  logic [31:0] in_lanes;

  always_comb begin
    in_misaligned = 1'b0;
    in_byte_sel   = 4'b0000;
    in_lanes      = 32'h0;
    case (req_size)
      2'b00: begin
        in_byte_sel = 4'b0001 << req_address[1:0];
        in_lanes    = {24'h0, req_writeData[7:0]} << {req_address[1:0], 3'b000};
      end
      2'b01: begin
        in_misaligned = req_address[0];
        in_byte_sel   = 4'b0011 << req_address[1:0];
        in_lanes      = {16'h0, req_writeData[15:0]} << {req_address[1], 4'b0000};
      end
      2'b10: begin
        in_misaligned = (req_address[1:0] != 2'b00);
        in_byte_sel   = 4'b1111;
        in_lanes      = req_writeData;
      end
      default: in_misaligned = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!RSTB) begin
      state          <= IDLE;
      busy_cnt       <= '0;
      lat_write      <= 1'b0;
      lat_size       <= 2'b00;
      lat_signed     <= 1'b0;
      lat_offset     <= 2'b00;
      lat_word_addr  <= '0;
      lat_byte_sel   <= '0;
      lat_lanes      <= '0;
      lat_misaligned <= 1'b0;
      lat_fault      <= 1'b0;
      lat_timeout    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            lat_write      <= req_write;
            lat_size       <= req_size;
            lat_signed     <= req_signed;
            lat_offset     <= req_address[1:0];
            lat_word_addr  <= req_address[31:2];
            lat_byte_sel   <= in_byte_sel;
            lat_lanes      <= in_lanes;
            lat_misaligned <= in_misaligned;
            lat_fault      <= 1'b0;
            lat_timeout    <= 1'b0;
            busy_cnt       <= '0;
            state          <= in_misaligned ? RESPOND : ACCESS;
          end
        end
        ACCESS: begin
          if (!data_memoryBusy) begin
            lat_fault <= data_memoryAccessFault;
            state     <= RESPOND;
          end else if (busy_cnt == CNT_LAST) begin
            // This busy cycle is the TIMEOUT_CYCLES-th one: abort.
            lat_fault   <= 1'b1;
            lat_timeout <= 1'b1;
            state       <= RESPOND;
          end else begin
            busy_cnt <= busy_cnt + 16'd1;
          end
        end
        RESPOND: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  logic        in_access;
  logic        in_respond;
  logic [31:0] shifted;
  logic [31:0] extended;

  assign in_access  = (state == ACCESS);
  assign in_respond = (state == RESPOND);
  assign dbg_state  = state;

  assign shifted = data_memoryDataRead >> {lat_offset, 3'b000};

  always_comb begin
    extended = shifted;
    case (lat_size)
      2'b00: extended = {{24{lat_signed & shifted[7]}}, shifted[7:0]};
      2'b01: extended = {{16{lat_signed & shifted[15]}}, shifted[15:0]};
      default: extended = shifted;
    endcase
  end

  assign req_ready              = (state == IDLE);
  assign data_memoryEnable      = in_access;
  assign data_memoryWriteEnable = in_access & lat_write;
  assign data_memoryAddress     = in_access ? {lat_word_addr, 2'b00} : 32'h0;
  assign data_memoryByteSelect  = in_access ? lat_byte_sel : 4'b0000;
  assign data_memoryDataWrite   = (in_access & lat_write) ? lat_lanes : 32'h0;

  assign rsp_valid      = in_respond;
  assign rsp_fault      = in_respond & lat_fault;
  assign rsp_timeout    = in_respond & lat_timeout;
  assign rsp_misaligned = in_respond & lat_misaligned;
  assign rsp_readData   = (in_respond & ~lat_write & ~lat_misaligned & ~lat_fault)
                          ? extended : 32'h0;

endmodule

// File: tb/tb_data_memory_initiator.sv
// Directed bench for data_memory_initiator: loads/stores with hand-computed
// lanes and results, misalignment, access fault, busy stretch, timeout, reset abort.
module tb_data_memory_initiator;

  logic        clk = 1'b0;
  logic        RSTB;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_address;
  logic [31:0] req_writeData;
  logic        rsp_valid;
  logic [31:0] rsp_readData;
  logic        rsp_fault;
  logic        rsp_timeout;
  logic        rsp_misaligned;
  logic [31:0] data_memoryAddress;
  logic [3:0]  data_memoryByteSelect;
  logic        data_memoryEnable;
  logic        data_memoryWriteEnable;
  logic [31:0] data_memoryDataWrite;
  logic [31:0] data_memoryDataRead;
  logic        data_memoryBusy;
  logic        data_memoryAccessFault;
  logic [1:0]  dbg_state;

  int checks = 0;
  int failures = 0;

  data_memory_initiator #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .RSTB(RSTB),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_address(req_address),
    .req_writeData(req_writeData),
    .rsp_valid(rsp_valid), .rsp_readData(rsp_readData), .rsp_fault(rsp_fault),
    .rsp_timeout(rsp_timeout), .rsp_misaligned(rsp_misaligned),
    .data_memoryAddress(data_memoryAddress), .data_memoryByteSelect(data_memoryByteSelect),
    .data_memoryEnable(data_memoryEnable), .data_memoryWriteEnable(data_memoryWriteEnable),
    .data_memoryDataWrite(data_memoryDataWrite), .data_memoryDataRead(data_memoryDataRead),
    .data_memoryBusy(data_memoryBusy), .data_memoryAccessFault(data_memoryAccessFault),
    .dbg_state(dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Drives one request during cycle T; returns at the negedge of cycle T+1.
  task automatic issue(input logic w, input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, input logic [31:0] wd);
    req_valid = 1'b1; req_write = w; req_size = sz; req_signed = sg;
    req_address = a; req_writeData = wd;
    check("accept_ready", {31'h0, req_ready}, 32'h1);
    step();
    req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00; req_signed = 1'b0;
    req_address = 32'h0; req_writeData = 32'h0;
  endtask

  // Plain load with busy low: checks memory request at T+1, response at T+2, ready at T+3.
  task automatic load(input string tag, input logic [1:0] sz, input logic sg,
                      input logic [31:0] a, input logic [3:0] exp_sel, input logic [31:0] exp_data);
    issue(1'b0, sz, sg, a, 32'h0);
    check({tag, "_en"},   {31'h0, data_memoryEnable}, 32'h1);
    check({tag, "_we"},   {31'h0, data_memoryWriteEnable}, 32'h0);
    check({tag, "_addr"}, data_memoryAddress, {a[31:2], 2'b00});
    check({tag, "_sel"},  {28'h0, data_memoryByteSelect}, {28'h0, exp_sel});
    step();
    check({tag, "_rv"},   {31'h0, rsp_valid}, 32'h1);
    check({tag, "_data"}, rsp_readData, exp_data);
    check({tag, "_flt"},  {29'h0, rsp_fault, rsp_timeout, rsp_misaligned}, 32'h0);
    check({tag, "_en_off"}, {31'h0, data_memoryEnable}, 32'h0);
    step();
    check({tag, "_idle"}, {30'h0, req_ready, rsp_valid}, 32'h2);
  endtask

  task automatic store(input string tag, input logic [1:0] sz, input logic [31:0] a,
                       input logic [31:0] wd, input logic [3:0] exp_sel, input logic [31:0] exp_dw);
    issue(1'b1, sz, 1'b0, a, wd);
    check({tag, "_we"},  {30'h0, data_memoryEnable, data_memoryWriteEnable}, 32'h3);
    check({tag, "_sel"}, {28'h0, data_memoryByteSelect}, {28'h0, exp_sel});
    check({tag, "_dw"},  data_memoryDataWrite, exp_dw);
    step();
    check({tag, "_rv"},   {31'h0, rsp_valid}, 32'h1);
    check({tag, "_data"}, rsp_readData, 32'h0);
    check({tag, "_dw_off"}, data_memoryDataWrite, 32'h0);
    step();
  endtask

  task automatic misaligned(input string tag, input logic [1:0] sz, input logic [31:0] a);
    issue(1'b0, sz, 1'b0, a, 32'h0);
    check({tag, "_en"},  {31'h0, data_memoryEnable}, 32'h0);
    check({tag, "_rsp"}, {28'h0, rsp_valid, rsp_fault, rsp_timeout, rsp_misaligned}, 32'h9);
    check({tag, "_data"}, rsp_readData, 32'h0);
    step();
    check({tag, "_idle"}, {30'h0, req_ready, rsp_valid}, 32'h2);
  endtask

  initial begin
    RSTB = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00; req_signed = 1'b0;
    req_address = 32'h0; req_writeData = 32'h0;
    data_memoryDataRead = 32'h8899AABB; data_memoryBusy = 1'b0; data_memoryAccessFault = 1'b0;
    repeat (3) step();
    RSTB = 1'b1;
    step();
    check("rst_ready", {31'h0, req_ready}, 32'h1);
    check("rst_outs", {28'h0, rsp_valid, rsp_fault, data_memoryEnable, data_memoryWriteEnable}, 32'h0);
    check("rst_addr", data_memoryAddress, 32'h0);
    check("rst_data", rsp_readData, 32'h0);

    load("lb_s_103",  2'b00, 1'b1, 32'h0000_0103, 4'b1000, 32'hFFFF_FF88);
    load("lhu_102",   2'b01, 1'b0, 32'h0000_0102, 4'b1100, 32'h0000_8899);
    load("lw_100",    2'b10, 1'b0, 32'h0000_0100, 4'b1111, 32'h8899_AABB);
    load("lbu_100",   2'b00, 1'b0, 32'h0000_0100, 4'b0001, 32'h0000_00BB);
    load("lh_s_100",  2'b01, 1'b1, 32'h0000_0100, 4'b0011, 32'hFFFF_AABB);
    load("lb_s_101",  2'b00, 1'b1, 32'h0000_0101, 4'b0010, 32'hFFFF_FFAA);

    store("sb_101", 2'b00, 32'h0000_0101, 32'h0000_005A, 4'b0010, 32'h0000_5A00);
    store("sh_102", 2'b01, 32'h0000_0102, 32'hFFFF_1234, 4'b1100, 32'h1234_0000);
    store("sw_104", 2'b10, 32'h0000_0104, 32'hDEAD_BEEF, 4'b1111, 32'hDEAD_BEEF);

    misaligned("lw_102", 2'b10, 32'h0000_0102);
    misaligned("lh_101", 2'b01, 32'h0000_0101);
    misaligned("rsv_100", 2'b11, 32'h0000_0100);

    // Access fault reported by the memory
    data_memoryAccessFault = 1'b1;
    issue(1'b0, 2'b10, 1'b0, 32'h0000_0200, 32'h0);
    step();
    check("afault_rsp", {28'h0, rsp_valid, rsp_fault, rsp_timeout, rsp_misaligned}, 32'hC);
    check("afault_data", rsp_readData, 32'h0);
    data_memoryAccessFault = 1'b0;
    step();

    // Busy for three ACCESS cycles, response at T+5
    data_memoryBusy = 1'b1;
    issue(1'b1, 2'b00, 1'b0, 32'h0000_0303, 32'h0000_00C3);
    for (int i = 1; i <= 3; i++) begin
      check($sformatf("busy_hold_sel%0d", i), {28'h0, data_memoryByteSelect}, 32'h8);
      check($sformatf("busy_hold_dw%0d", i), data_memoryDataWrite, 32'hC300_0000);
      check($sformatf("busy_hold_rv%0d", i), {30'h0, data_memoryEnable, rsp_valid}, 32'h2);
      step();
    end
    check("busy_t4_en", {30'h0, data_memoryEnable, rsp_valid}, 32'h2);
    data_memoryBusy = 1'b0;
    step();
    check("busy_t5_rsp", {28'h0, rsp_valid, rsp_fault, rsp_timeout, rsp_misaligned}, 32'h8);
    step();

    // Busy stuck: abort after 4 ACCESS cycles
    data_memoryBusy = 1'b1;
    issue(1'b0, 2'b10, 1'b0, 32'h0000_0400, 32'h0);
    for (int i = 1; i <= 4; i++) begin
      check($sformatf("to_wait%0d", i), {30'h0, data_memoryEnable, rsp_valid}, 32'h2);
      step();
    end
    check("to_rsp", {28'h0, rsp_valid, rsp_fault, rsp_timeout, rsp_misaligned}, 32'hE);
    check("to_en", {31'h0, data_memoryEnable}, 32'h0);
    check("to_data", rsp_readData, 32'h0);
    step();
    check("to_idle", {31'h0, req_ready}, 32'h1);

    // Reset while in ACCESS
    issue(1'b0, 2'b10, 1'b0, 32'h0000_0500, 32'h0);
    check("rab_en", {31'h0, data_memoryEnable}, 32'h1);
    RSTB = 1'b0;
    step();
    check("rab_off", {30'h0, data_memoryEnable, rsp_valid}, 32'h0);
    RSTB = 1'b1;
    data_memoryBusy = 1'b0;
    step();
    check("rab_ready", {30'h0, req_ready, rsp_valid}, 32'h2);
    load("post_rst_lw", 2'b10, 1'b0, 32'h0000_0100, 4'b1111, 32'h8899_AABB);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
